// File: rtl/block_ram_sdp.sv
// block_ram_sdp: simple dual-port block RAM (write port A, read port B) with
// per-byte write enables, optional output register, and a clear sweep engine
// that zeroes the whole array one word per cycle.
// Optional feature macro: BLOCK_RAM_SDP_BYPASS_EN selects write-first per byte
// lane on a same-cycle same-address read/write; read-first when undefined.
module block_ram_sdp #(
    parameter int    ADDR_WIDTH = 14,
    parameter int    DATA_WIDTH = 32,
    parameter int    OUT_REG    = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clka,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   addra,
    input  logic [DATA_WIDTH-1:0]   dina,
    input  logic [DATA_WIDTH/8-1:0] wea,
    input  logic                    reb,
    input  logic [ADDR_WIDTH-1:0]   addrb,
    output logic [DATA_WIDTH-1:0]   doutb,
    output logic                    doutb_vld,
    input  logic                    clr_req,
    output logic                    clr_busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

`ifdef BLOCK_RAM_SDP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_busy;
    logic                  w_rd_acc;
    logic [NB-1:0]         w_lane_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  r_vld_p0;
    logic [DATA_WIDTH-1:0] r_dout_p0;

    assign w_busy   = (r_state == S_CLEAR);
    assign w_rd_acc = reb & ~w_busy;
    assign clr_busy = w_busy;

    // Write port source: the sweep owns the array while busy, port A otherwise.
    always_comb begin
        w_lane_we = wea;
        w_waddr   = addra;
        w_wdata   = dina;
        if (w_busy) begin
            w_lane_we = {NB{1'b1}};
            w_waddr   = r_cnt;
            w_wdata   = '0;
        end
    end

    // Sweep state machine: IDLE waits for clr_req, CLEAR walks every word once.
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Byte-lane write into the array (no reset on storage).
    always_ff @(posedge clka) begin
        for (int i = 0; i < NB; i++) begin
            if (w_lane_we[i]) begin
                r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // Read word with optional per-lane forwarding of same-cycle write data.
    always_comb begin
        w_rd_word = r_mem[addrb];
        if (BYPASS && !w_busy && (addra == addrb)) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) begin
                    w_rd_word[8*i +: 8] = dina[8*i +: 8];
                end
            end
        end
    end

    // Stage p0: capture accepted read; data holds when nothing is accepted.
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_vld_p0  <= 1'b0;
            r_dout_p0 <= '0;
        end else begin
            r_vld_p0 <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout_p0 <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG == 1) begin : g_oreg
            logic                  r_vld_p1;
            logic [DATA_WIDTH-1:0] r_dout_p1;

            // Stage p1: extra output register, loads only on a valid result.
            always_ff @(posedge clka or negedge rstn) begin
                if (!rstn) begin
                    r_vld_p1  <= 1'b0;
                    r_dout_p1 <= '0;
                end else begin
                    r_vld_p1 <= r_vld_p0;
                    if (r_vld_p0) begin
                        r_dout_p1 <= r_dout_p0;
                    end
                end
            end

            assign doutb     = r_dout_p1;
            assign doutb_vld = r_vld_p1;
        end else begin : g_noreg
            assign doutb     = r_dout_p0;
            assign doutb_vld = r_vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_block_ram_sdp.sv
// Testbench for block_ram_sdp: two 16-word instances (latency 1 and 2) share
// stimulus; a reference model feeds per-instance scoreboards of timed results.
module tb_block_ram_sdp;

`ifdef BLOCK_RAM_SDP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  addra, addrb;
    logic [31:0] dina;
    logic [3:0]  wea;
    logic        reb, clr_req;
    logic [31:0] dout0, dout1;
    logic        vld0, vld1, busy0, busy1;

    always #5 clk = ~clk;

    block_ram_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(0)) u_dut0 (
        .clka(clk), .rstn(rstn), .addra(addra), .dina(dina), .wea(wea),
        .reb(reb), .addrb(addrb), .doutb(dout0), .doutb_vld(vld0),
        .clr_req(clr_req), .clr_busy(busy0)
    );

    block_ram_sdp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(1)) u_dut1 (
        .clka(clk), .rstn(rstn), .addra(addra), .dina(dina), .wea(wea),
        .reb(reb), .addrb(addrb), .doutb(dout1), .doutb_vld(vld1),
        .clr_req(clr_req), .clr_busy(busy1)
    );

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    typedef struct {
        logic [3:0]  aa;
        logic [31:0] di;
        logic [3:0]  we;
        logic        re;
        logic [3:0]  ab;
        logic [31:0] ex_byp;
        logic [31:0] ex_rf;
    } vec_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m_mem [16];
    bit          m_busy;
    int          m_cnt;
    int          cyc;
    logic [31:0] last0, last1;
    bit          mon_en;
    int          busy_cycles;
    int          n_vec, n_err;
    vec_t        tv [12];

    function automatic logic [31:0] model_rd(input logic [3:0] aa, input logic [31:0] di,
                                             input logic [3:0] we, input logic [3:0] ab);
        logic [31:0] r;
        r = m_mem[ab];
        if (BYP && (aa == ab)) begin
            for (int l = 0; l < 4; l++) begin
                if (we[l]) r[8*l +: 8] = di[8*l +: 8];
            end
        end
        return r;
    endfunction

    task automatic chk_out(input string nm, input int k, input logic v, input logic [31:0] d);
        exp_t        e;
        bit          hit;
        logic [31:0] lst;
        lst = (k == 0) ? last0 : last1;
        hit = 1'b0;
        if (k == 0) begin
            if (q0.size() > 0 && q0[0].due == cyc) begin
                e = q0.pop_front();
                hit = 1'b1;
                last0 = e.d;
            end
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                hit = 1'b1;
                last1 = e.d;
            end
        end
        n_vec++;
        if (hit) begin
            if (v !== 1'b1 || d !== e.d) begin
                n_err++;
                $display("FAIL %s_read cyc=%0d: vld=%b doutb=%h, want vld=1 doutb=%h", nm, cyc, v, d, e.d);
            end
        end else if (v !== 1'b0 || d !== lst) begin
            n_err++;
            $display("FAIL %s_idle cyc=%0d: vld=%b doutb=%h, want vld=0 doutb=%h", nm, cyc, v, d, lst);
        end
    endtask

    // Scoreboard and busy monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk_out("dut0", 0, vld0, dout0);
            chk_out("dut1", 1, vld1, dout1);
            n_vec++;
            if (busy0 !== m_busy || busy1 !== m_busy) begin
                n_err++;
                $display("FAIL clr_busy cyc=%0d: got %b/%b, want %b", cyc, busy0, busy1, m_busy);
            end
            if (busy0 === 1'b1) busy_cycles++;
        end
    end

    task automatic step(input logic [3:0] aa, input logic [31:0] di, input logic [3:0] we,
                        input logic re, input logic [3:0] ab, input logic cr,
                        input bit use_ex, input logic [31:0] ex);
        exp_t        e;
        logic [31:0] v;
        addra = aa; dina = di; wea = we; reb = re; addrb = ab; clr_req = cr;
        @(posedge clk);
        if (rstn) begin
            if (re && !m_busy) begin
                v = use_ex ? ex : model_rd(aa, di, we, ab);
                e.d = v; e.due = cyc + 1; q0.push_back(e);
                e.due = cyc + 2;          q1.push_back(e);
            end
            if (m_busy) begin
                m_mem[m_cnt] = 32'h0;
                if (m_cnt == 15) begin
                    m_busy = 1'b0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                for (int l = 0; l < 4; l++) begin
                    if (we[l]) m_mem[aa][8*l +: 8] = di[8*l +: 8];
                end
                if (cr) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic fill(input bit with_reads);
        for (int i = 0; i < 16; i++) begin
            step(4'(i), $urandom | 32'h0100_0000, 4'hF, with_reads && (i > 0), 4'(i - 1),
                 1'b0, 1'b0, 32'h0);
        end
        idle(3);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) step(4'h0, 32'h0, 4'h0, 1'b1, 4'(i), 1'b0, 1'b0, 32'h0);
        idle(3);
    endtask

    initial begin
        tv[0]  = '{4'd5, 32'h1122_3344, 4'hF, 1'b0, 4'd0, 32'h0, 32'h0};
        tv[1]  = '{4'd5, 32'hAABB_CCDD, 4'h5, 1'b0, 4'd0, 32'h0, 32'h0};
        tv[2]  = '{4'd0, 32'h0,         4'h0, 1'b1, 4'd5, 32'h11BB_33DD, 32'h11BB_33DD};
        tv[3]  = '{4'd9, 32'h0,         4'hF, 1'b0, 4'd0, 32'h0, 32'h0};
        tv[4]  = '{4'd9, 32'hFFFF_FFFF, 4'h3, 1'b1, 4'd9, 32'h0000_FFFF, 32'h0000_0000};
        tv[5]  = '{4'd0, 32'h0,         4'h0, 1'b1, 4'd9, 32'h0000_FFFF, 32'h0000_FFFF};
        tv[6]  = '{4'd3, 32'hCAFE_F00D, 4'hF, 1'b1, 4'd5, 32'h11BB_33DD, 32'h11BB_33DD};
        tv[7]  = '{4'd3, 32'h1234_5678, 4'h8, 1'b1, 4'd3, 32'h12FE_F00D, 32'hCAFE_F00D};
        tv[8]  = '{4'd3, 32'h1234_5678, 4'h0, 1'b1, 4'd3, 32'h12FE_F00D, 32'h12FE_F00D};
        tv[9]  = '{4'd0, 32'h0,         4'h0, 1'b0, 4'd0, 32'h0, 32'h0};
        tv[10] = '{4'd5, 32'hFFFF_FFFF, 4'h2, 1'b1, 4'd9, 32'h0000_FFFF, 32'h0000_FFFF};
        tv[11] = '{4'd0, 32'h0,         4'h0, 1'b1, 4'd5, 32'h11BB_FFDD, 32'h11BB_FFDD};

        rstn = 1'b0; addra = '0; dina = '0; wea = '0; reb = 1'b0; addrb = '0; clr_req = 1'b0;
        mon_en = 1'b0; cyc = 0; m_busy = 1'b0; m_cnt = 0; last0 = '0; last1 = '0;
        busy_cycles = 0; n_vec = 0; n_err = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;

        idle(2);
        mon_en = 1'b1;
        idle(2);
        rstn = 1'b1;

        // Fill with concurrent reads of the previously written word.
        fill(1'b1);

        // Byte-lane and same-address vectors.
        for (int i = 0; i < 12; i++) begin
            step(tv[i].aa, tv[i].di, tv[i].we, tv[i].re, tv[i].ab, 1'b0, 1'b1,
                 BYP ? tv[i].ex_byp : tv[i].ex_rf);
        end
        idle(3);

        // Back-to-back reads of words 0..7.
        for (int i = 0; i < 8; i++) step(4'h0, 32'h0, 4'h0, 1'b1, 4'(i), 1'b0, 1'b0, 32'h0);
        idle(3);

        // Full sweep with writes, reads and a repeated clr_req while busy.
        fill(1'b0);
        busy_cycles = 0;
        step(4'h0, 32'h0, 4'h0, 1'b1, 4'd2, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 16; k++) begin
            step(4'($urandom_range(15)), $urandom | 32'h1, 4'hF, 1'b1,
                 4'($urandom_range(15)), k == 4, 1'b0, 32'h0);
        end
        idle(2);
        n_vec++;
        if (busy_cycles != 16) begin
            n_err++;
            $display("FAIL sweep_len: busy for %0d cycles, want 16", busy_cycles);
        end
        read_all();

        // Reset six cycles into a sweep.
        fill(1'b1);
        step(4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h0);
        idle(6);
        rstn = 1'b0;
        #1;
        n_vec++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || vld0 !== 1'b0 || vld1 !== 1'b0 ||
            dout0 !== 32'h0 || dout1 !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b/%b vld=%b/%b doutb=%h/%h, want all 0",
                     busy0, busy1, vld0, vld1, dout0, dout1);
        end
        m_busy = 1'b0; m_cnt = 0; q0.delete(); q1.delete(); last0 = '0; last1 = '0;
        idle(2);
        rstn = 1'b1;
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/block_ram_sdp.md
BLOCK_RAM_SDP -- requirements
Module: block_ram_sdp

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 14, word-address width; depth = 2**ADDR_WIDTH words.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, word width; legal values are multiples of 8; NB = DATA_WIDTH/8 byte lanes.
REQ-003 The module SHALL have parameter OUT_REG, default 0, output register stages; 0 gives read latency 1, 1 gives read latency 2.
REQ-004 The module SHALL have parameter INIT_FILE, default "" (none), hex image loaded at elaboration when non-empty.
REQ-005 The module SHALL have port clka, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port addra, input, ADDR_WIDTH bits: write word address.
REQ-008 The module SHALL have port dina, input, DATA_WIDTH bits: write data.
REQ-009 The module SHALL have port wea, input, NB bits: per-byte write enables; bit i covers dina[8i+7:8i].
REQ-010 The module SHALL have port reb, input, 1 bit: read request.
REQ-011 The module SHALL have port addrb, input, ADDR_WIDTH bits: read word address.
REQ-012 The module SHALL have port doutb, output, DATA_WIDTH bits: read data.
REQ-013 The module SHALL have port doutb_vld, output, 1 bit: doutb carries the result of a request this cycle.
REQ-014 The module SHALL have port clr_req, input, 1 bit: single-cycle pulse that starts a memory clear sweep.
REQ-015 The module SHALL have port clr_busy, output, 1 bit: clear sweep in progress.

Function
REQ-016 A write SHALL update only the byte lanes whose wea bit is 1 at addra; other lanes keep their contents.
REQ-017 A read accepted at cycle N SHALL assert doutb_vld for exactly one cycle at N+1 when OUT_REG=0 and at N+2 when OUT_REG=1, with doutb valid in that same cycle.
REQ-018 Back-to-back reads SHALL be accepted every cycle at full throughput with no bubbles.
REQ-019 doutb SHALL hold its last value when no result is being delivered.
REQ-020 The state machine SHALL have states IDLE and CLEAR.
REQ-021 In IDLE, clr_req=1 SHALL move the machine to CLEAR with the sweep counter at 0.
REQ-022 In CLEAR, the module SHALL write all-zero to word[counter] once per cycle and increment the counter.
REQ-023 After writing word 2**ADDR_WIDTH-1, the machine SHALL return to IDLE; clr_busy SHALL then be 0 from the next cycle.
REQ-024 A full sweep SHALL take exactly 2**ADDR_WIDTH cycles with clr_busy=1.
REQ-025 While clr_busy=1, port-A writes SHALL be ignored and reads SHALL be dropped: no doutb_vld, and doutb unchanged.
REQ-026 clr_req while busy SHALL be ignored.
REQ-027 Reads already in flight when a sweep starts SHALL still complete normally.
REQ-028 Counter wrap SHALL end the sweep and SHALL never restart it.
REQ-029 A read and a write to different addresses in the same cycle SHALL both complete independently.

Reset
REQ-030 Asserting rstn=0 SHALL immediately force state IDLE, sweep counter 0, clr_busy 0, doutb_vld 0, doutb 0, and flush all pipeline valid bits.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 A reset during CLEAR SHALL abort the sweep, leaving words 0..counter-1 zero and the remaining words unchanged.
REQ-033 The first request SHALL be accepted on the first rising edge after rstn deasserts.

Configuration
REQ-034 Macro BLOCK_RAM_SDP_BYPASS_EN defined: a same-cycle read and write to the same address SHALL return the new bytes for lanes with wea=1 and the old bytes for all other lanes (write-first per lane).
REQ-035 Macro BLOCK_RAM_SDP_BYPASS_EN undefined: a same-cycle read and write to the same address SHALL return the complete old word (read-first).
REQ-036 Latency SHALL be identical with and without the macro.

Verification
REQ-037 Write 0x11223344 to addr 5 with wea=0xF, then write 0xAABBCCDD to addr 5 with wea=0x5, then read addr 5 -> doutb=0x11BB33DD.
REQ-038 OUT_REG=1, reads of addr 0..7 on consecutive cycles -> doutb_vld high for 8 consecutive cycles starting 2 cycles after the first request, with data in order.
REQ-039 Same cycle: old addr 9 = 0x0, write 0xFFFFFFFF with wea=0x3, read addr 9 -> 0x0000FFFF with BYPASS_EN, 0x00000000 without.
REQ-040 ADDR_WIDTH=4, memory fully written, clr_req pulse -> clr_busy high exactly 16 cycles; writes issued during the sweep are discarded; all 16 words then read 0.
REQ-041 ADDR_WIDTH=4, rstn pulled low 6 cycles into a sweep -> clr_busy and doutb_vld drop at once; words 0..5 read 0 and words 6..15 read their old values.
